// File: rtl/gtp_link_mgr.sv
// Multi-lane GTP/Aurora bring-up manager: sequences the shared PLL reset and per-lane resets,
// debounces lane status, and retries failed lanes up to a limit.
module gtp_link_mgr #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned RST_CYCLES    = 1000,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned UP_TIMEOUT    = 1048575,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 7,
    parameter int unsigned CNT_W         = 20
) (
    input  logic                   init_clk_i,
    input  logic                   gtp_reset_ni,
    input  logic                   enable_i,
    input  logic                   pll_lock_i,
    input  logic [NUM_LANES-1:0]   channel_up_i,
    input  logic [NUM_LANES-1:0]   lane_up_i,
    output logic                   common_reset_o,
    output logic [NUM_LANES-1:0]   gt_rst_o,
    output logic [NUM_LANES-1:0]   gtp_up_o,
    output logic                   all_up_o,
    output logic [NUM_LANES-1:0]   link_fail_o,
    output logic [4*NUM_LANES-1:0] retry_cnt_o
);

    localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] UpLast    = CNT_W'(UP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0]       RetryMax  = 4'(MAX_RETRY);

    typedef enum logic [1:0] {CRst, CLock, CRun} c_state_e;
    typedef enum logic [1:0] {LRst, LWait, LUp, LFail} l_state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [1:0]           lock_sync_q;
    logic [NUM_LANES-1:0] ch_s0_q, ch_s1_q, ln_s0_q, ln_s1_q;
    logic                 lock_s, pll_ok;
    logic [NUM_LANES-1:0] lane_ok;

    c_state_e             c_state_q, c_state_d;
    logic [CNT_W-1:0]     c_timer_q, c_timer_d;
    logic                 common_reset_q;

    l_state_e             l_state_q [NUM_LANES];
    l_state_e             l_state_d [NUM_LANES];
    logic [CNT_W-1:0]     l_timer_q [NUM_LANES];
    logic [CNT_W-1:0]     l_timer_d [NUM_LANES];
    logic [CNT_W-1:0]     l_stable_q [NUM_LANES];
    logic [CNT_W-1:0]     l_stable_d [NUM_LANES];
    logic [3:0]           l_retry_q [NUM_LANES];
    logic [3:0]           l_retry_d [NUM_LANES];

    logic [NUM_LANES-1:0] gt_rst_d, gtp_up_d, link_fail_d;
    logic [NUM_LANES-1:0] gt_rst_q, gtp_up_q, link_fail_q;
    logic                 all_up_q;

    assign lock_s  = lock_sync_q[1];
    assign lane_ok = ch_s1_q & ln_s1_q;
    assign pll_ok  = (c_state_q == CRun);

    always_comb begin
        c_state_d = c_state_q;
        c_timer_d = c_timer_q + 1'b1;
        if (!enable_i) begin
            c_state_d = CRst;
            c_timer_d = '0;
        end else begin
            unique case (c_state_q)
                CRst: if (c_timer_q == RstLast) begin
                    c_state_d = CLock;
                    c_timer_d = '0;
                end
                CLock: if (lock_s) begin
                    c_state_d = CRun;
                    c_timer_d = '0;
                end else if (c_timer_q == LockLast) begin
                    c_state_d = CRst;
                    c_timer_d = '0;
                end
                CRun: begin
                    // Lock loss only re-waits for lock; the reset re-pulses via the lock timeout.
                    c_timer_d = '0;
                    if (!lock_s) c_state_d = CLock;
                end
                default: begin
                    c_state_d = CRst;
                    c_timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            l_state_d[i]  = l_state_q[i];
            l_timer_d[i]  = l_timer_q[i] + 1'b1;
            l_stable_d[i] = '0;
            l_retry_d[i]  = l_retry_q[i];
            if (!enable_i) begin
                l_state_d[i] = LRst;
                l_timer_d[i] = '0;
                l_retry_d[i] = '0;
            end else if (!pll_ok && l_state_q[i] != LFail) begin
                l_state_d[i] = LRst;
                l_timer_d[i] = '0;
            end else begin
                unique case (l_state_q[i])
                    LRst: if (l_timer_q[i] == RstLast) begin
                        l_state_d[i] = LWait;
                        l_timer_d[i] = '0;
                    end
                    LWait: begin
                        l_stable_d[i] = lane_ok[i] ? l_stable_q[i] + 1'b1 : '0;
                        // Stable completion takes priority over a coincident timeout.
                        if (l_stable_q[i] == StableCnt) begin
                            l_state_d[i]  = LUp;
                            l_timer_d[i]  = '0;
                            l_stable_d[i] = '0;
                            l_retry_d[i]  = '0;
                        end else if (l_timer_q[i] == UpLast) begin
                            l_retry_d[i] = sat_inc(l_retry_q[i]);
                            l_timer_d[i] = '0;
                            l_state_d[i] = (l_retry_d[i] >= RetryMax) ? LFail : LRst;
                        end
                    end
                    LUp: begin
                        l_timer_d[i] = '0;
                        if (!lane_ok[i]) begin
                            l_state_d[i] = LRst;
                            l_retry_d[i] = sat_inc(l_retry_q[i]);
                        end
                    end
                    default: l_timer_d[i] = '0;
                endcase
            end
            gt_rst_d[i]    = (l_state_d[i] == LRst) || (l_state_d[i] == LFail);
            gtp_up_d[i]    = (l_state_d[i] == LUp);
            link_fail_d[i] = (l_state_d[i] == LFail);
        end
    end

    always_ff @(posedge init_clk_i or negedge gtp_reset_ni) begin
        if (!gtp_reset_ni) begin
            lock_sync_q    <= '0;
            ch_s0_q        <= '0;
            ch_s1_q        <= '0;
            ln_s0_q        <= '0;
            ln_s1_q        <= '0;
            c_state_q      <= CRst;
            c_timer_q      <= '0;
            common_reset_q <= 1'b1;
            gt_rst_q       <= '1;
            gtp_up_q       <= '0;
            link_fail_q    <= '0;
            all_up_q       <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                l_state_q[i]  <= LRst;
                l_timer_q[i]  <= '0;
                l_stable_q[i] <= '0;
                l_retry_q[i]  <= '0;
            end
        end else begin
            lock_sync_q    <= {lock_sync_q[0], pll_lock_i};
            ch_s0_q        <= channel_up_i;
            ch_s1_q        <= ch_s0_q;
            ln_s0_q        <= lane_up_i;
            ln_s1_q        <= ln_s0_q;
            c_state_q      <= c_state_d;
            c_timer_q      <= c_timer_d;
            common_reset_q <= (c_state_d == CRst);
            gt_rst_q       <= gt_rst_d;
            gtp_up_q       <= gtp_up_d;
            link_fail_q    <= link_fail_d;
            all_up_q       <= &gtp_up_q;
            for (int i = 0; i < NUM_LANES; i++) begin
                l_state_q[i]  <= l_state_d[i];
                l_timer_q[i]  <= l_timer_d[i];
                l_stable_q[i] <= l_stable_d[i];
                l_retry_q[i]  <= l_retry_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_retry
        assign retry_cnt_o[4*g +: 4] = l_retry_q[g];
    end

    assign common_reset_o = common_reset_q;
    assign gt_rst_o       = gt_rst_q;
    assign gtp_up_o       = gtp_up_q;
    assign all_up_o       = all_up_q;
    assign link_fail_o    = link_fail_q;

endmodule

// File: tb/tb_gtp_link_mgr.sv
// Bench for gtp_link_mgr: hand-timed bring-up/glitch sequences plus a table of steady-state phases.
module tb_gtp_link_mgr;

    logic       clk = 1'b0;
    logic       rst_n, enable, pll_lock;
    logic [1:0] ch, ln;
    logic       common_reset, all_up;
    logic [1:0] gt_rst, gtp_up, link_fail;
    logic [7:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;
    logic flag;

    typedef struct {
        string      name;
        logic       en;
        logic       lock;
        logic [1:0] ch;
        logic [1:0] ln;
        int         cycles;
        logic       hold0;
        logic       exp_cr;
        logic [1:0] exp_gr;
        logic [1:0] exp_up;
        logic       exp_all;
        logic [1:0] exp_fail;
        logic [7:0] exp_retry;
    } vec_t;

    vec_t vecs[6];
    vec_t sb[$];
    vec_t e;

    always #5 clk = ~clk;

    gtp_link_mgr #(
        .NUM_LANES    (2),
        .RST_CYCLES   (8),
        .LOCK_TIMEOUT (32),
        .UP_TIMEOUT   (64),
        .STABLE_CYCLES(4),
        .MAX_RETRY    (3),
        .CNT_W        (20)
    ) dut (
        .init_clk_i    (clk),
        .gtp_reset_ni  (rst_n),
        .enable_i      (enable),
        .pll_lock_i    (pll_lock),
        .channel_up_i  (ch),
        .lane_up_i     (ln),
        .common_reset_o(common_reset),
        .gt_rst_o      (gt_rst),
        .gtp_up_o      (gtp_up),
        .all_up_o      (all_up),
        .link_fail_o   (link_fail),
        .retry_cnt_o   (retry_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_common_reset"}, common_reset, 1'b1);
        chk({tag, "_gt_rst"}, gt_rst, 2'b11);
        chk({tag, "_gtp_up"}, gtp_up, 2'b00);
        chk({tag, "_all_up"}, all_up, 1'b0);
        chk({tag, "_link_fail"}, link_fail, 2'b00);
        chk({tag, "_retry_cnt"}, retry_cnt, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"pll_down", 1, 0, 2'b11, 2'b11, 10,  0, 0, 2'b11, 2'b00, 0, 2'b00, 8'h00};
        vecs[1] = '{"relock",   1, 1, 2'b11, 2'b11, 40,  0, 0, 2'b00, 2'b11, 1, 2'b00, 8'h00};
        vecs[2] = '{"lane1_bad",1, 1, 2'b01, 2'b11, 250, 1, 0, 2'b10, 2'b01, 0, 2'b10, 8'h30};
        vecs[3] = '{"disable",  0, 1, 2'b11, 2'b11, 3,   0, 1, 2'b11, 2'b00, 0, 2'b00, 8'h00};
        vecs[4] = '{"reenable", 1, 1, 2'b11, 2'b11, 60,  0, 0, 2'b00, 2'b11, 1, 2'b00, 8'h00};
        vecs[5] = '{"ups_lost", 1, 1, 2'b00, 2'b00, 30,  0, 0, 2'b00, 2'b00, 0, 2'b00, 8'h11};

        rst_n = 1'b0; enable = 1'b1; pll_lock = 1'b0; ch = 2'b00; ln = 2'b00;
        repeat (3) step();
        chk_reset_vals("por");
        rst_n = 1'b1;

        // PLL never locks: reset pulse 8, lock wait 32, pulse 8 again; lanes stay in reset.
        flag = 1'b1;
        cnt = 0;
        do begin step(); cnt++; if (gt_rst != 2'b11) flag = 1'b0; end
        while (common_reset !== 1'b0 && cnt < 200);
        chk("common_rst_width", cnt, 8);
        cnt = 0;
        do begin step(); cnt++; if (gt_rst != 2'b11) flag = 1'b0; end
        while (common_reset !== 1'b1 && cnt < 200);
        chk("lock_timeout", cnt, 32);
        cnt = 0;
        do begin step(); cnt++; if (gt_rst != 2'b11) flag = 1'b0; end
        while (common_reset !== 1'b0 && cnt < 200);
        chk("common_rst_repulse", cnt, 8);
        chk("gt_rst_held_nolock", flag, 1'b1);

        // Nominal bring-up.
        repeat (5) step();
        pll_lock = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (gt_rst !== 2'b00 && cnt < 200);
        chk("gt_rst_release", cnt, 11);
        ch = 2'b11; ln = 2'b11;
        cnt = 0;
        do begin step(); cnt++; end while (gtp_up !== 2'b11 && cnt < 200);
        chk("gtp_up_latency", cnt, 7);
        chk("all_up_lag0", all_up, 1'b0);
        step();
        chk("all_up_lag1", all_up, 1'b1);

        // One-cycle drop in L_UP on lane0.
        ch[0] = 1'b0; ln[0] = 1'b0;
        step();
        ch = 2'b11; ln = 2'b11;
        cnt = 1;
        while (gtp_up[0] !== 1'b0 && cnt < 200) begin step(); cnt++; end
        chk("up_drop_latency", cnt, 3);
        chk("up_drop_retry0", retry_cnt[3:0], 4'd1);
        chk("up_drop_lane1", gtp_up[1], 1'b1);
        cnt = 0;
        do begin step(); cnt++; end while (gt_rst[0] !== 1'b0 && cnt < 200);
        chk("gt_rst0_pulse", cnt, 8);

        // Glitch during the stable count restarts it.
        ch[0] = 1'b0; ln[0] = 1'b0;
        step();
        ch = 2'b11; ln = 2'b11;
        cnt = 1;
        while (gtp_up[0] !== 1'b1 && cnt < 200) begin step(); cnt++; end
        chk("stable_restart", cnt, 8);
        chk("reup_retry_clear", retry_cnt, 8'h00);
        chk("glitch_lane1", gtp_up[1], 1'b1);

        // PLL lock loss with both lanes up.
        pll_lock = 1'b0;
        cnt = 0;
        do begin step(); cnt++; end while (gtp_up !== 2'b00 && cnt < 200);
        chk("pll_loss_latency", cnt, 4);

        for (int v = 0; v < 6; v++) begin
            enable   = vecs[v].en;
            pll_lock = vecs[v].lock;
            ch       = vecs[v].ch;
            ln       = vecs[v].ln;
            sb.push_back(vecs[v]);
            flag = 1'b1;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step();
                if (gtp_up[0] !== 1'b1) flag = 1'b0;
            end
            e = sb.pop_front();
            chk({e.name, "_common_reset"}, common_reset, e.exp_cr);
            chk({e.name, "_gt_rst"}, gt_rst, e.exp_gr);
            chk({e.name, "_gtp_up"}, gtp_up, e.exp_up);
            chk({e.name, "_all_up"}, all_up, e.exp_all);
            chk({e.name, "_link_fail"}, link_fail, e.exp_fail);
            chk({e.name, "_retry_cnt"}, retry_cnt, e.exp_retry);
            if (e.hold0) chk({e.name, "_lane0_held"}, flag, 1'b1);
        end

        // Asynchronous reset while lanes sit in WAIT with nonzero retry counts.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
